// File: rtl/zz_pingpong_ctrl_if.sv
// zz_pingpong_ctrl_if
//   Bundles the raster input stream, the zigzag scanner handshake and the
//   zigzag-order output stream of the ping-pong coefficient buffer.
//   Modports:
//     slave  - buffer side (takes raster data and scanner coordinates,
//              drives in_ready, zz_start, the output stream and scan_err)
//     master - environment side (source, scanner and sink)
//   Signals: in_data/in_valid/in_ready, zz_start, zz_x/zz_y/zz_valid/zz_done,
//            out_data/out_valid/out_sob/out_eob, out_ready, scan_err.
interface zz_pingpong_ctrl_if #(
  parameter int COL = 8,
  parameter int ROW = 8,
  parameter int DW  = 12
);
  localparam int XW = $clog2(COL);
  localparam int YW = $clog2(ROW);

  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          zz_start;
  logic [XW-1:0] zz_x;
  logic [YW-1:0] zz_y;
  logic          zz_valid;
  logic          zz_done;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_sob;
  logic          out_eob;
  logic          out_ready;
  logic          scan_err;

  modport slave (
    input  in_data, in_valid,
    output in_ready,
    output zz_start,
    input  zz_x, zz_y, zz_valid, zz_done,
    output out_data, out_valid, out_sob, out_eob,
    input  out_ready,
    output scan_err
  );

  modport master (
    output in_data, in_valid,
    input  in_ready,
    input  zz_start,
    output zz_x, zz_y, zz_valid, zz_done,
    input  out_data, out_valid, out_sob, out_eob,
    output out_ready,
    input  scan_err
  );
endinterface

// File: rtl/zz_pingpong_ctrl.sv
// zz_pingpong_ctrl
//   Ping-pong coefficient buffer and scan sequencer in front of the zigzag
//   address generator. Raster-order COLxROW blocks are written into two banks;
//   a full bank starts the external scanner, and the bank is read at the
//   scanner's (x,y) to emit the block in zigzag order.
//   Ports:
//     clk  - clock, rising edge
//     rst  - asynchronous, active-high reset
//     bus  - zz_pingpong_ctrl_if.slave (input stream, scanner handshake,
//            output stream, scan_err)
//   Optional: define ZZ_SCAN_CHK_EN to build the scan-sequence checker that
//   drives the sticky scan_err flag; otherwise scan_err is tied low.
//
//   Read FSM states
//   state | meaning
//   IDLE  | waiting for full[rbank] and out_ready
//   START | one-cycle zz_start pulse to the scanner
//   SCAN  | reading rbank at scanner (x,y) until zz_done
module zz_pingpong_ctrl #(
  parameter int COL = 8,
  parameter int ROW = 8,
  parameter int DW  = 12
) (
  input logic            clk,
  input logic            rst,
  zz_pingpong_ctrl_if.slave bus
);
  localparam int N  = COL * ROW;
  localparam int AW = $clog2(N);

  typedef enum logic [1:0] {IDLE, START, SCAN} state_t;

  state_t        state, state_n;
  logic [DW-1:0] mem [2*N];
  logic [1:0]    full, full_n;
  logic          wbank, rbank;
  logic [AW-1:0] wcnt;
  logic [AW:0]   rcnt;
  logic          wr_fire, wr_last;
  logic          rd_fire, rel;
  logic          zz_start_c;

  // Writer owns full[wbank]==0 banks only, so the read side never sees a
  // bank that is still being filled.
  assign bus.in_ready = !rst && !full[wbank];
  assign wr_fire      = bus.in_valid && bus.in_ready;
  assign wr_last      = wr_fire && (wcnt == AW'(N - 1));
  assign bus.zz_start = zz_start_c;

  always_ff @(posedge clk) begin
    if (wr_fire) mem[{wbank, wcnt}] <= bus.in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    zz_start_c = 1'b0;
    rd_fire    = 1'b0;
    rel        = 1'b0;
    case (state)
      IDLE:  if (full[rbank] && bus.out_ready) state_n = START;
      START: begin
        zz_start_c = 1'b1;
        state_n    = SCAN;
      end
      SCAN: begin
        rd_fire = bus.zz_valid;
        if (bus.zz_done) begin
          rel     = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Fill of one bank and release of the other can land in the same cycle.
  always_comb begin
    full_n = full;
    if (wr_last) full_n[wbank] = 1'b1;
    if (rel)     full_n[rbank] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full          <= 2'b00;
      wbank         <= 1'b0;
      rbank         <= 1'b0;
      wcnt          <= '0;
      rcnt          <= '0;
      bus.out_valid <= 1'b0;
      bus.out_sob   <= 1'b0;
      bus.out_eob   <= 1'b0;
      bus.out_data  <= '0;
    end else begin
      full <= full_n;
      if (wr_fire) wcnt <= wr_last ? '0 : wcnt + AW'(1);
      if (wr_last) wbank <= ~wbank;
      if (rel)          rcnt <= '0;
      else if (rd_fire) rcnt <= rcnt + (AW+1)'(1);
      if (rel) rbank <= ~rbank;
      bus.out_valid <= rd_fire;
      bus.out_sob   <= rd_fire && (rcnt == '0);
      bus.out_eob   <= rd_fire && (rcnt == (AW+1)'(N - 1));
      // {y,x} is y*COL+x because COL is a power of two.
      if (rd_fire) bus.out_data <= mem[{rbank, bus.zz_y, bus.zz_x}];
    end
  end

`ifdef ZZ_SCAN_CHK_EN
  logic          err_q, err_set;
  logic [AW:0]   tmo;
  logic [AW:0]   rcnt_inc;

  // Count includes a read landing in the same cycle as zz_done.
  assign rcnt_inc = rcnt + {{AW{1'b0}}, rd_fire};

  // tmo is loaded with N+2 in START; reaching 1 in SCAN without zz_done
  // means the scanner overran its window.
  assign err_set = (bus.zz_valid && (state != SCAN))
                || (rel && (rcnt_inc != (AW+1)'(N)))
                || ((state == SCAN) && !bus.zz_done && (tmo == (AW+1)'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
      tmo   <= '0;
    end else begin
      if (state == START)                  tmo <= (AW+1)'(N + 2);
      else if ((state == SCAN) && tmo != '0) tmo <= tmo - (AW+1)'(1);
      if (err_set) err_q <= 1'b1;
    end
  end

  assign bus.scan_err = err_q;
`else
  assign bus.scan_err = 1'b0;
`endif
endmodule

// File: tb/tb_zz_pingpong_ctrl.sv
module tb_zz_pingpong_ctrl;
  localparam int COL = 8;
  localparam int ROW = 8;
  localparam int DW  = 12;
  localparam int N   = COL * ROW;
  localparam int XW  = $clog2(COL);
  localparam int YW  = $clog2(ROW);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  zz_pingpong_ctrl_if #(.COL(COL), .ROW(ROW), .DW(DW)) bus ();
  zz_pingpong_ctrl #(.COL(COL), .ROW(ROW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0, n_fail = 0;
  int zx [N];
  int zy [N];
  logic [DW-1:0] acc [$];
  int rd_blk = 0, rd_pos = 0, rel_cnt = 0;
  int n_out = 0, n_start = 0;
  int inject = 0;
  int scan_lim;
  bit scan_abort;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Zigzag order by anti-diagonals: even diagonals walk up (y falling),
  // odd diagonals walk down (y rising).
  task automatic build_zigzag();
    int p, lo, hi;
    p = 0;
    for (int s = 0; s <= COL + ROW - 2; s++) begin
      lo = (s > COL - 1) ? s - (COL - 1) : 0;
      hi = (s < ROW - 1) ? s : ROW - 1;
      if (s % 2 == 1) begin
        for (int y = lo; y <= hi; y++) begin zy[p] = y; zx[p] = s - y; p++; end
      end else begin
        for (int y = hi; y >= lo; y--) begin zy[p] = y; zx[p] = s - y; p++; end
      end
    end
  endtask

  // Scanner model: after zz_start, N (or 'inject') coordinates, then zz_done.
  initial begin
    bus.zz_valid = 1'b0; bus.zz_done = 1'b0; bus.zz_x = '0; bus.zz_y = '0;
    forever begin
      @(negedge clk);
      if (bus.zz_start && !rst) begin
        scan_lim = (inject > 0) ? inject : N;
        scan_abort = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < scan_lim; i++) begin
          if (rst) begin scan_abort = 1'b1; break; end
          bus.zz_valid = 1'b1; bus.zz_x = XW'(zx[i]); bus.zz_y = YW'(zy[i]);
          @(posedge clk); #1;
        end
        bus.zz_valid = 1'b0;
        if (!scan_abort && !rst) begin
          bus.zz_done = 1'b1;
          @(posedge clk); #1;
          bus.zz_done = 1'b0;
        end
      end
    end
  end

  // Reference: accepted words form blocks in order; each block must come out
  // as word[blk*N + y*COL + x] over the zigzag table. in_ready is high while
  // fewer than two completed blocks await release.
  always @(negedge clk) begin
    int idx;
    if (!rst) begin
      chk("in_ready", bus.in_ready, ((acc.size() / N - rel_cnt) < 2) ? 1 : 0);
      if (bus.out_valid) begin
        idx = rd_blk * N + zy[rd_pos] * COL + zx[rd_pos];
        if (idx < acc.size()) chk("out_data", bus.out_data, acc[idx]);
        else                  chk("out_unexpected", 1, 0);
        chk("out_sob", bus.out_sob, (rd_pos == 0) ? 1 : 0);
        chk("out_eob", bus.out_eob, (rd_pos == N - 1) ? 1 : 0);
        n_out++;
        rd_pos++;
        if (rd_pos == N) begin rd_pos = 0; rd_blk++; end
      end
      if (bus.zz_done) begin
        rel_cnt++;
        if (rd_pos != 0) begin rd_pos = 0; rd_blk++; end
      end
      if (bus.zz_start) n_start++;
      if (bus.in_valid && bus.in_ready) acc.push_back(bus.in_data);
    end
  end

  // Called at posedge+1; returns at posedge+1 of the accepting edge.
  task automatic put(input logic [DW-1:0] d, input int budget, output bit ok);
    bus.in_valid = 1'b1; bus.in_data = d; ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk); ok = bus.in_ready;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) begin @(posedge clk); #1; end
  endtask

  initial begin
    bit ok, got;
    int cnt, s0, o0, r0;
    build_zigzag();
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;

    // T1 reset
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("t1_in_ready", bus.in_ready, 0);
    chk("t1_out_valid", bus.out_valid, 0);
    chk("t1_zz_start", bus.zz_start, 0);
    chk("t1_scan_err", bus.scan_err, 0);
    chk("t1_out_data", bus.out_data, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t1_ready_after", bus.in_ready, 1);
    @(posedge clk); #1;

    // T2 one ramp block
    bus.out_ready = 1'b1;
    for (int i = 0; i < N; i++) put(DW'(i), 4, ok);
    got = 1'b0;
    for (int k = 0; k < 300 && !got; k++) begin @(negedge clk); #1; got = (rd_blk == 1); end
    chk("t2_wait", got, 1);
    cycles(3);
    chk("t2_starts", n_start, 1);
    chk("t2_outs", n_out, N);

    // T3 fill both banks
    bus.out_ready = 1'b0;
    cnt = 0;
    for (int i = 0; i < 2 * N + 2; i++) begin
      put(DW'(i), 3, ok);
      if (ok) cnt++;
    end
    chk("t3_accepted", cnt, 2 * N);
    chk("t3_in_ready", bus.in_ready, 0);
    cycles(5);
    chk("t3_no_start", n_start, 1);

    // T4 release both
    bus.out_ready = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 300 && !got; k++) begin @(negedge clk); #1; got = (rel_cnt == 2); end
    chk("t4_wait_done", got, 1);
    chk("t4_rdy_at_done", bus.in_ready, 0);
    @(negedge clk);
    chk("t4_rdy_after_done", bus.in_ready, 1);
    got = 1'b0;
    for (int k = 0; k < 300 && !got; k++) begin @(negedge clk); #1; got = (rd_blk == 3); end
    chk("t4_wait_drain", got, 1);
    @(posedge clk); #1;
    cycles(3);
    chk("t4_starts", n_start, 3);
    chk("t4_outs", n_out, 3 * N);

    // T5 reset mid-scan
    bus.out_ready = 1'b0;
    for (int i = 0; i < N; i++) put(DW'($urandom), 4, ok);
    bus.out_ready = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 300 && !got; k++) begin @(negedge clk); #1; got = (rd_pos == 20); end
    chk("t5_wait", got, 1);
    rst = 1'b1;
    #1;
    chk("t5_out_valid", bus.out_valid, 0);
    chk("t5_out_sob", bus.out_sob, 0);
    chk("t5_out_eob", bus.out_eob, 0);
    chk("t5_out_data", bus.out_data, 0);
    chk("t5_in_ready", bus.in_ready, 0);
    acc.delete(); rd_blk = 0; rd_pos = 0; rel_cnt = 0;
    s0 = n_start; o0 = n_out;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cycles(100);
    chk("t5_no_start", n_start, s0);
    chk("t5_no_out", n_out, o0);
    chk("t5_ready", bus.in_ready, 1);

    // T7 random traffic
    for (int c = 0; c < 2000; c++) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_data  = DW'($urandom);
      if (c % 25 == 0) bus.out_ready = $urandom_range(0, 1) != 0;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 3000 && !got; k++) begin
      @(negedge clk); #1; got = (rd_blk == acc.size() / N) && (rd_pos == 0);
    end
    chk("t7_wait_drain", got, 1);
    @(posedge clk); #1;
    cycles(4);
    chk("t7_blocks", rd_blk, acc.size() / N);
    chk("t7_starts", n_start - s0, rd_blk);
    chk("t7_scan_err", bus.scan_err, 0);

`ifdef ZZ_SCAN_CHK_EN
    // T6 short scan
    bus.out_ready = 1'b0;
    s0 = n_start; o0 = n_out; r0 = rel_cnt;
    inject = 10;
    for (int i = 0; i < N; i++) put(DW'($urandom), 4, ok);
    bus.out_ready = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 300 && !got; k++) begin @(negedge clk); #1; got = (rel_cnt == r0 + 1); end
    chk("t6_wait_done", got, 1);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    cycles(2);
    chk("t6_scan_err", bus.scan_err, 1);
    chk("t6_outs", n_out - o0, 10);
    cycles(20);
    chk("t6_err_held", bus.scan_err, 1);
    chk("t6_starts", n_start - s0, 1);
    inject = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
